// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm timer: state encoding, digit width and the 59 ceiling.
package alarm_pkg;

    localparam int VAL_W = 6;
    localparam logic [VAL_W-1:0] MAX_VAL = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALERT = 2'd3
    } state_t;

endpackage

// File: rtl/alarm_timer_if.sv
// Control pulses and display outputs of the alarm timer. All inputs are single-cycle
// pulses sampled on the rising clock edge; outputs are registered and change one edge later.
interface alarm_timer_if;
    import alarm_pkg::*;

    logic             tick;
    logic             inc_min;
    logic             inc_sec;
    logic             start;
    logic             clr;
    logic [VAL_W-1:0] minutes;
    logic [VAL_W-1:0] seconds;
    logic             running;
    logic             alert;

    modport master (
        output tick, inc_min, inc_sec, start, clr,
        input  minutes, seconds, running, alert
    );

    modport slave (
        input  tick, inc_min, inc_sec, start, clr,
        output minutes, seconds, running, alert
    );

endinterface

// File: rtl/alarm_timer_mod60_counter.sv
// Modulo-60 digit register with load-zero, increment and decrement (wrapping both ways).
// o_borrow is high while the value is zero, i.e. the next decrement would borrow.
module mod60_counter
    import alarm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_zero,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [VAL_W-1:0] o_val,
    output logic             o_borrow
);

    logic [VAL_W-1:0] r_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= '0;
        end else if (i_zero) begin
            r_val <= '0;
        end else if (i_inc) begin
            r_val <= (r_val == MAX_VAL) ? '0 : r_val + 1'b1;
        end else if (i_dec) begin
            r_val <= (r_val == '0) ? MAX_VAL : r_val - 1'b1;
        end
    end

    assign o_val    = r_val;
    assign o_borrow = (r_val == '0);

endmodule

// File: rtl/alarm_timer.sv
// Kitchen-style countdown timer: set mm:ss, run on 1 Hz ticks, alert for ALERT_TICKS ticks.
// Define ALARM_BLINK_EN to make alert toggle on every tick while alerting.
module alarm_timer
    import alarm_pkg::*;
#(
    parameter int ALERT_TICKS = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    alarm_timer_if.slave  bus,
    output state_t        o_dbg_state
);

    localparam logic [7:0] LAST_TICK = 8'(ALERT_TICKS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_acnt;
    logic [7:0]       w_acnt_next;
    logic             r_alert;
    logic             w_alert_next;
    logic             r_running;
    logic             w_zero;
    logic             w_sec_inc;
    logic             w_sec_dec;
    logic             w_min_inc;
    logic             w_min_dec;
    logic             w_sec_borrow;
    logic             w_min_borrow;
    logic [VAL_W-1:0] w_sec_val;
    logic [VAL_W-1:0] w_min_val;

    mod60_counter u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_zero   (w_zero),
        .i_inc    (w_sec_inc),
        .i_dec    (w_sec_dec),
        .o_val    (w_sec_val),
        .o_borrow (w_sec_borrow)
    );

    mod60_counter u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_zero   (w_zero),
        .i_inc    (w_min_inc),
        .i_dec    (w_min_dec),
        .o_val    (w_min_val),
        .o_borrow (w_min_borrow)
    );

    // Priority: clr > start > tick > inc_*.
    always_comb begin
        w_next       = r_state;
        w_acnt_next  = r_acnt;
        w_alert_next = r_alert;
        w_zero       = 1'b0;
        w_sec_inc    = 1'b0;
        w_sec_dec    = 1'b0;
        w_min_inc    = 1'b0;
        w_min_dec    = 1'b0;
        if (bus.clr) begin
            w_next       = ST_IDLE;
            w_zero       = 1'b1;
            w_acnt_next  = '0;
            w_alert_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !(w_sec_borrow && w_min_borrow)) begin
                        w_next = ST_RUN;
                    end else begin
                        w_min_inc = bus.inc_min;
                        w_sec_inc = bus.inc_sec;
                    end
                end
                ST_RUN: begin
                    if (bus.start) begin
                        w_next = ST_PAUSE;
                    end else if (bus.tick) begin
                        w_sec_dec = 1'b1;
                        w_min_dec = w_sec_borrow;
                        // This tick lands on 00:00, so alert starts on the same edge.
                        if (w_min_borrow && w_sec_val == 6'd1) begin
                            w_next       = ST_ALERT;
                            w_alert_next = 1'b1;
                            w_acnt_next  = '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start) w_next = ST_RUN;
                end
                ST_ALERT: begin
                    if (bus.start) begin
                        w_next       = ST_IDLE;
                        w_alert_next = 1'b0;
                        w_acnt_next  = '0;
                    end else if (bus.tick) begin
                        if (r_acnt == LAST_TICK) begin
                            w_next       = ST_IDLE;
                            w_alert_next = 1'b0;
                            w_acnt_next  = '0;
                        end else begin
                            w_acnt_next = r_acnt + 1'b1;
`ifdef ALARM_BLINK_EN
                            w_alert_next = !r_alert;
`endif
                        end
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acnt    <= '0;
            r_alert   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_acnt    <= w_acnt_next;
            r_alert   <= w_alert_next;
            r_running <= (w_next == ST_RUN);
        end
    end

    assign bus.minutes = w_min_val;
    assign bus.seconds = w_sec_val;
    assign bus.running = r_running;
    assign bus.alert   = r_alert;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alarm_timer.sv
// Bench for alarm_timer: directed scenarios plus random pulses, checked every cycle
// against a total-seconds model of the timer. Honours ALARM_BLINK_EN like the design.
module tb_alarm_timer;
    import alarm_pkg::*;

    localparam int AT = 10;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;
    int     tests = 0;
    int     fails = 0;

    alarm_timer_if bus ();

    alarm_timer #(.ALERT_TICKS(AT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode plus time, counted down as total seconds.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALERT = 3;
    int mode = M_IDLE;
    int mm = 0, ss = 0, acnt = 0;
    bit alert_m = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int t;
        if (!rst_n) begin
            mode = M_IDLE; mm = 0; ss = 0; acnt = 0; alert_m = 1'b0;
        end else if (bus.clr) begin
            mode = M_IDLE; mm = 0; ss = 0; acnt = 0; alert_m = 1'b0;
        end else begin
            case (mode)
                M_IDLE: begin
                    if (bus.start && (mm * 60 + ss) != 0) mode = M_RUN;
                    else begin
                        if (bus.inc_min) mm = (mm + 1) % 60;
                        if (bus.inc_sec) ss = (ss + 1) % 60;
                    end
                end
                M_RUN: begin
                    if (bus.start) mode = M_PAUSE;
                    else if (bus.tick) begin
                        t = mm * 60 + ss - 1;
                        mm = t / 60;
                        ss = t % 60;
                        if (t == 0) begin mode = M_ALERT; alert_m = 1'b1; acnt = 0; end
                    end
                end
                M_PAUSE: if (bus.start) mode = M_RUN;
                default: begin
                    if (bus.start) begin mode = M_IDLE; alert_m = 1'b0; acnt = 0; end
                    else if (bus.tick) begin
                        acnt = acnt + 1;
                        if (acnt == AT) begin mode = M_IDLE; alert_m = 1'b0; acnt = 0; end
`ifdef ALARM_BLINK_EN
                        else alert_m = !alert_m;
`endif
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        check("cyc_minutes", int'(bus.minutes), mm);
        check("cyc_seconds", int'(bus.seconds), ss);
        check("cyc_running", int'(bus.running), int'(mode == M_RUN));
        check("cyc_alert",   int'(bus.alert),   int'(alert_m));
    end

    task automatic step(input bit t, input bit im, input bit is, input bit st, input bit cl);
        @(negedge clk);
        bus.tick = t; bus.inc_min = im; bus.inc_sec = is; bus.start = st; bus.clr = cl;
        @(posedge clk);
        #1;
        bus.tick = 0; bus.inc_min = 0; bus.inc_sec = 0; bus.start = 0; bus.clr = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic set_time(input int m, input int s);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < m; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < s; i++) step(0, 0, 1, 0, 0);
    endtask

    task automatic lit(input string name, input int m, input int s, input int run, input int al);
        check({name, "_min"}, int'(bus.minutes), m);
        check({name, "_sec"}, int'(bus.seconds), s);
        check({name, "_run"}, int'(bus.running), run);
        check({name, "_alert"}, int'(bus.alert), al);
    endtask

    initial begin
        bus.tick = 0; bus.inc_min = 0; bus.inc_sec = 0; bus.start = 0; bus.clr = 0;
        #12;
        lit("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        set_time(3, 5);
        lit("set_0305", 3, 5, 0, 0);

        set_time(0, 60);
        lit("sec_wrap", 0, 0, 0, 0);
        set_time(60, 0);
        lit("min_wrap", 0, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        lit("start_zero", 1, 1, 0, 0);
        check("start_zero_state", int'(dbg_state), int'(ST_IDLE));

        set_time(1, 0);
        step(0, 0, 0, 1, 0);
        lit("run_0100", 1, 0, 1, 0);
        ticks(1);
        lit("tick_0059", 0, 59, 1, 0);
        step(1, 1, 1, 0, 0);
        lit("inc_ignored", 0, 58, 1, 0);
        ticks(58);
        lit("reach_zero", 0, 0, 0, 1);
        check("alert_state", int'(dbg_state), int'(ST_ALERT));
        ticks(AT - 1);
        check("alert_before_last", int'(dbg_state), int'(ST_ALERT));
        ticks(1);
        lit("alert_done", 0, 0, 0, 0);
        check("idle_after_alert", int'(dbg_state), int'(ST_IDLE));

        set_time(0, 1);
        step(0, 0, 0, 1, 0);
        ticks(1);
        lit("alert2", 0, 0, 0, 1);
        ticks(2);
        step(1, 0, 0, 1, 0);
        lit("ack", 0, 0, 0, 0);

        set_time(0, 31);
        step(0, 0, 0, 1, 0);
        ticks(1);
        lit("run_0030", 0, 30, 1, 0);
        step(1, 0, 0, 1, 0);
        lit("pause_0030", 0, 30, 0, 0);
        check("pause_state", int'(dbg_state), int'(ST_PAUSE));
        ticks(5);
        lit("pause_hold", 0, 30, 0, 0);
        step(0, 0, 0, 1, 0);
        ticks(1);
        lit("resume", 0, 29, 1, 0);

        set_time(2, 15);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        lit("clr_run", 0, 0, 0, 0);

        set_time(0, 1);
        step(0, 0, 0, 1, 0);
        ticks(1);
        lit("pre_rst_alert", 0, 0, 0, 1);
        rst_n = 1'b0;
        #2;
        lit("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 0, 0);
        lit("post_rst", 1, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 59) == 0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_timer.md
ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 SHALL have parameter ALERT_TICKS, default 10: number of tick pulses alert stays asserted (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tick  input  1  one-cycle 1 Hz enable pulse.
REQ-005 SHALL have port inc_min  input  1  one-cycle pulse (pre-debounced), add one minute.
REQ-006 SHALL have port inc_sec  input  1  one-cycle pulse (pre-debounced), add one second.
REQ-007 SHALL have port start  input  1  one-cycle pulse: start/pause/acknowledge.
REQ-008 SHALL have port clr  input  1  one-cycle pulse: abort and zero.
REQ-009 SHALL have port minutes  output  6  binary 0..59 for the tens/units 7-segment decoders.
REQ-010 SHALL have port seconds  output  6  binary 0..59 for the tens/units 7-segment decoders.
REQ-011 SHALL have port running  output  1  high only in RUN.
REQ-012 SHALL have port alert  output  1  alarm indicator.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, ALERT; all outputs registered, one-cycle latency from input to output.
REQ-014 SHALL, in IDLE, on inc_min set minutes to (minutes+1) mod 60 (59->0), on inc_sec set seconds to (seconds+1) mod 60 with no carry into minutes; both in one cycle SHALL both apply.
REQ-015 SHALL, in IDLE, on start with time not 00:00 enter RUN; start at 00:00 SHALL be ignored.
REQ-016 SHALL, in RUN, on tick: seconds>0 -> seconds-1; seconds=0 and minutes>0 -> seconds=59, minutes-1.
REQ-017 SHALL enter ALERT on the same edge the count reaches 00:00; no tick SHALL be needed beyond the one producing 00:00.
REQ-018 SHALL, in RUN, on start enter PAUSE; inc_min/inc_sec SHALL be ignored in RUN, PAUSE, ALERT.
REQ-019 SHALL, in PAUSE, ignore tick and hold time; start SHALL return to RUN.
REQ-020 SHALL, in ALERT, hold minutes/seconds at 0, count ALERT_TICKS ticks, then enter IDLE on the edge of the last counted tick.
REQ-021 SHALL, in ALERT, on start (acknowledge) enter IDLE immediately, alert deasserting next cycle.
REQ-022 SHALL, on clr in any state, enter IDLE with minutes=0, seconds=0, alert=0, alert counter cleared.
REQ-023 SHALL apply priority clr > start > tick > inc_*; start and tick in the same RUN cycle SHALL pause with the tick discarded.
REQ-024 SHALL never present minutes or seconds outside 0..59.

Reset
REQ-025 SHALL, while rst_n low, force state IDLE, minutes=0, seconds=0, running=0, alert=0, alert counter=0, independent of clk.
REQ-026 SHALL, on reset assertion mid-RUN or mid-ALERT, abandon operation; first post-reset edge SHALL behave as IDLE.

Configuration
REQ-027 SHALL support macro ALARM_BLINK_EN: defined -> alert asserts on ALERT entry and toggles on each tick while in ALERT; undefined -> alert held constantly high throughout ALERT.

Structure
REQ-028 SHALL take the state enumeration, MAX_VAL=59 and the 6-bit value width from shared package alarm_pkg.
REQ-029 SHALL instantiate sub-module mod60_counter (load-zero, increment, decrement with wrap/borrow flag) twice, for minutes and seconds.

Verification
REQ-030 SHALL cover: reset, 3x inc_min, 5x inc_sec -> minutes=3, seconds=5, running=0, alert=0.
REQ-031 SHALL cover: 60x inc_sec from 00:00 -> seconds=0, minutes=0 (wrap, no carry).
REQ-032 SHALL cover: set 01:00, start, 1 tick -> 00:59; 59 more ticks -> 00:00, ALERT same edge, alert=1.
REQ-033 SHALL cover: ALERT with ALERT_TICKS=10 -> IDLE after 10th tick; start on tick 3 -> IDLE next cycle.
REQ-034 SHALL cover: RUN at 00:30, start and tick same cycle -> PAUSE, seconds stays 30; 5 ticks -> still 30.
REQ-035 SHALL cover: clr asserted with start in RUN at 02:15 -> IDLE, 00:00; rst_n pulsed mid-ALERT -> all outputs 0 without a clock edge.
